// File: rtl/hog_cell_hist_accum.sv
// Per-cell orientation histogram accumulator: clears a histogram RAM, accumulates a raster pixel
// stream with a 2-stage read-modify-write (forwarded, saturating) and offers gated readback.
module hog_cell_hist_accum #(
    parameter int IMG_W     = 136,
    parameter int IMG_H     = 136,
    parameter int CELL_SIZE = 4,
    parameter int NUM_BINS  = 18,
    parameter int MAG_W     = 16,
    parameter int ACC_W     = 35,
    localparam int BIN_W    = $clog2(NUM_BINS),
    localparam int AW       = $clog2((IMG_W / CELL_SIZE) * (IMG_H / CELL_SIZE) * NUM_BINS)
) (
    input  logic             aclk,
    input  logic             arest_n,
    input  logic             start,
    output logic             hog_ready,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [BIN_W-1:0] pix_bin,
    input  logic [MAG_W-1:0] pix_mag,
    input  logic             pix_last,
    output logic             hist_done,
    output logic             frame_err,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [ACC_W-1:0] rd_data,
    output logic [2:0]       dbg_state
);
    // Handshake: a pixel transfers on any cycle where pix_valid && pix_ready; pix_ready does not
    // depend on pix_valid, and the pipeline never stalls once a pixel is accepted.
    localparam int CELLS_X = IMG_W / CELL_SIZE;
    localparam int CELLS_Y = IMG_H / CELL_SIZE;
    localparam int DEPTH   = CELLS_X * CELLS_Y * NUM_BINS;
    localparam int CS_LOG  = $clog2(CELL_SIZE);
    localparam int CW      = $clog2(IMG_W + 1);
    localparam int RW      = $clog2(IMG_H + 1);
    localparam int PW      = $clog2(IMG_W * IMG_H + 1);

    localparam logic [CW-1:0]    COL_MAX   = CW'(IMG_W - 1);
    localparam logic [CW-1:0]    GRID_W    = CW'(CELLS_X * CELL_SIZE);
    localparam logic [RW-1:0]    GRID_H    = RW'(CELLS_Y * CELL_SIZE);
    localparam logic [PW-1:0]    PIX_FINAL = PW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]      DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [BIN_W:0]   NBINS_C   = (BIN_W + 1)'(NUM_BINS);
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    clr_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [PW-1:0]    pix_cnt_q;
    logic             err_q;
    logic             s1_valid_q, s1_occ_q, s1_fwd_q;
    logic [AW-1:0]    s1_addr_q;
    logic [MAG_W-1:0] s1_mag_q;
    logic [ACC_W-1:0] sum_q, ram_rd_q;
    logic             rd_ok_q;

    logic [ACC_W-1:0] mem [DEPTH];

    logic             start_ok, accept, last_pix, frame_end, bin_ok, in_grid, s0_go, fwd_d;
    logic             rd_in_range;
    logic [AW-1:0]    acc_addr, rd_sel;
    logic [ACC_W-1:0] old_val, sum;
    logic [ACC_W:0]   wide_sum;

    assign start_ok    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign accept      = pix_valid && (state_q == S_ACCUM);
    assign last_pix    = (pix_cnt_q == PIX_FINAL);
    assign frame_end   = accept && (pix_last || last_pix);
    assign bin_ok      = {1'b0, pix_bin} < NBINS_C;
    assign in_grid     = (col_q < GRID_W) && (row_q < GRID_H);
    assign s0_go       = accept && bin_ok && in_grid;
    assign acc_addr    = AW'((int'(row_q >> CS_LOG) * CELLS_X + int'(col_q >> CS_LOG)) * NUM_BINS
                             + int'(pix_bin));
    assign fwd_d       = s0_go && s1_valid_q && (acc_addr == s1_addr_q);
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;

    // The RAM read of a pixel following a same-address pixel returns the pre-write value,
    // so the sum registered alongside that write stands in for it.
    assign old_val  = s1_fwd_q ? sum_q : ram_rd_q;
    assign wide_sum = {1'b0, old_val} + (ACC_W + 1)'(s1_mag_q);
    assign sum      = wide_sum[ACC_W] ? ACC_MAX : wide_sum[ACC_W-1:0];

    always_comb begin
        rd_sel = '0;
        if (state_q == S_DONE) begin
            if (rd_in_range) rd_sel = rd_addr;
        end else if (s0_go) begin
            rd_sel = acc_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_CLEAR;
            S_CLEAR: if (clr_q == ADDR_LAST) state_d = S_ACCUM;
            S_ACCUM: if (frame_end) state_d = S_DRAIN;
            S_DRAIN: if (!s1_occ_q) state_d = S_DONE;
            S_DONE:  if (start_ok) state_d = S_CLEAR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state_q    <= S_IDLE;
            clr_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pix_cnt_q  <= '0;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_occ_q   <= 1'b0;
            s1_fwd_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_mag_q   <= '0;
            sum_q      <= '0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s0_go;
            s1_occ_q   <= accept;
            s1_fwd_q   <= fwd_d;
            rd_ok_q    <= (state_q == S_DONE) && rd_en && rd_in_range;
            if (s0_go) begin
                s1_addr_q <= acc_addr;
                s1_mag_q  <= pix_mag;
            end
            if (s1_valid_q) sum_q <= sum;
            if (state_q == S_CLEAR) clr_q <= clr_q + 1'b1;
            if (start_ok) begin
                clr_q     <= '0;
                col_q     <= '0;
                row_q     <= '0;
                pix_cnt_q <= '0;
                err_q     <= 1'b0;
            end else if (accept) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
                if (col_q == COL_MAX) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                if ((pix_last != last_pix) || !bin_ok) err_q <= 1'b1;
            end
        end
    end

    // Histogram RAM: contents are only meaningful after a full CLEAR pass.
    always_ff @(posedge aclk) begin
        if (state_q == S_CLEAR) mem[clr_q] <= '0;
        else if (s1_valid_q) mem[s1_addr_q] <= sum;
        ram_rd_q <= mem[rd_sel];
    end

    assign hog_ready = (state_q == S_ACCUM);
    assign pix_ready = hog_ready;
    assign hist_done = (state_q == S_DONE);
    assign frame_err = err_q;
    assign rd_data   = (rd_ok_q && state_q == S_DONE) ? ram_rd_q : '0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hog_cell_hist_accum.sv
// Bench for hog_cell_hist_accum on a reduced 10x9 geometry with 8-bit accumulators, so that
// clear, partial-cell pixels, forwarding and saturation are all reachable in a short run.
module tb_hog_cell_hist_accum;
    localparam int IMG_W   = 10;
    localparam int IMG_H   = 9;
    localparam int CS      = 4;
    localparam int NB      = 18;
    localparam int MAG_W   = 8;
    localparam int ACC_W   = 8;
    localparam int CELLS_X = IMG_W / CS;
    localparam int CELLS_Y = IMG_H / CS;
    localparam int DEPTH   = CELLS_X * CELLS_Y * NB;
    localparam int AW      = $clog2(DEPTH);
    localparam int BIN_W   = $clog2(NB);
    localparam int TOTAL   = IMG_W * IMG_H;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             aclk = 1'b0;
    logic             arest_n;
    logic             start;
    logic             hog_ready, pix_ready;
    logic             pix_valid;
    logic [BIN_W-1:0] pix_bin;
    logic [MAG_W-1:0] pix_mag;
    logic             pix_last;
    logic             hist_done, frame_err;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [ACC_W-1:0] rd_data;
    logic [2:0]       dbg_state;

    hog_cell_hist_accum #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CELL_SIZE(CS), .NUM_BINS(NB), .MAG_W(MAG_W), .ACC_W(ACC_W)
    ) dut (
        .aclk(aclk), .arest_n(arest_n), .start(start), .hog_ready(hog_ready),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_bin(pix_bin), .pix_mag(pix_mag),
        .pix_last(pix_last), .hist_done(hist_done), .frame_err(frame_err), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    logic [ACC_W-1:0] exp_q[$];
    int model [DEPTH];
    int col_m, row_m, cnt_m;
    bit m_armed;

    typedef struct {
        string name;
        int    bin_base;
        int    bin_step;
        int    mag_base;
        int    mag_step;   // negative: random magnitude
        int    last_at;    // 1-based pixel carrying pix_last, 0 = never
        bit    exp_err;
    } frame_t;

    frame_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // driver tasks
    task automatic do_start();
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_state_clear", dbg_state, 3'd1);
        check("start_hist_done_low", hist_done, 1'b0);
        check("start_err_cleared", frame_err, 1'b0);
        n = 0;
        while (!hog_ready && n < DEPTH + 20) begin
            step();
            n++;
        end
        check("clear_cycles", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        col_m = 0;
        row_m = 0;
        cnt_m = 0;
        m_armed = 1'b1;
    endtask

    task automatic send_pix(input int bin, input int mag, input bit last);
        int a;
        pix_valid = 1'b1;
        pix_bin   = BIN_W'(bin);
        pix_mag   = MAG_W'(mag);
        pix_last  = last;
        check("pix_ready", pix_ready, m_armed);
        if (m_armed) begin
            if (bin < NB && col_m < CELLS_X * CS && row_m < CELLS_Y * CS) begin
                a = ((row_m / CS) * CELLS_X + col_m / CS) * NB + bin;
                model[a] = (model[a] + mag > ACC_MAX) ? ACC_MAX : model[a] + mag;
            end
            cnt_m++;
            if (col_m == IMG_W - 1) begin
                col_m = 0;
                row_m++;
            end else begin
                col_m++;
            end
            if (last || cnt_m == TOTAL) m_armed = 1'b0;
        end
        step();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    // Called right after the edge that took the final pixel; optionally offers one more pixel.
    task automatic finish_frame(input bit extra);
        pix_valid = extra;
        pix_bin   = '0;
        pix_mag   = MAG_W'(99);
        step();
        pix_valid = 1'b0;
        check("hog_ready_dropped", hog_ready, 1'b0);
        check("hist_done_not_yet", hist_done, 1'b0);
        step();
        check("hist_done_2_cycles", hist_done, 1'b1);
    endtask

    // scoreboard: expected pushed when the read is issued, popped when data returns
    task automatic read_one(input int addr, input int exp);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        exp_q.push_back(ACC_W'(exp));
        step();
        rd_en = 1'b0;
        check($sformatf("rd_data[%0d]", addr), rd_data, exp_q.pop_front());
    endtask

    task automatic readback_all();
        for (int a = 0; a < DEPTH; a++) read_one(a, model[a]);
        read_one(DEPTH, 0);
    endtask

    task automatic run_frame(input frame_t f);
        int bin, mag;
        do_start();
        for (int i = 0; i < TOTAL && m_armed; i++) begin
            bin = (f.bin_base + f.bin_step * i) % NB;
            mag = (f.mag_step < 0) ? int'($urandom_range(0, 30)) : (f.mag_base + f.mag_step * i) % 256;
            send_pix(bin, mag, (i + 1 == f.last_at));
        end
        finish_frame(1'b0);
        check({f.name, "_frame_err"}, frame_err, f.exp_err);
        readback_all();
    endtask

    initial begin
        vecs[0] = '{"uniform_b3", 3, 0, 1, 0, TOTAL, 1'b0};
        vecs[1] = '{"alt_rand",   2, 9, 0, -1, TOTAL, 1'b0};
        vecs[2] = '{"ramp_early", 0, 1, 10, 3, 50, 1'b1};
        vecs[3] = '{"no_last",    17, 0, 2, 0, 0, 1'b1};

        arest_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_bin = '0; pix_mag = '0;
        pix_last = 1'b0; rd_en = 1'b0; rd_addr = '0;
        #2;
        check("rst_hog_ready", hog_ready, 1'b0);
        check("rst_hist_done", hist_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rd_data", rd_data, 0);
        check("rst_state", dbg_state, 3'd0);
        step();
        step();
        arest_n = 1'b1;
        step();

        // clear length and all-zero readback after a one-pixel zero-magnitude frame
        do_start();
        send_pix(0, 0, 1'b1);
        finish_frame(1'b0);
        check("t1_frame_err_early_last", frame_err, 1'b1);
        readback_all();

        foreach (vecs[v]) begin
            run_frame(vecs[v]);
            if (v == 0) begin
                for (int c = 0; c < CELLS_X * CELLS_Y; c++) begin
                    read_one(c * NB + 3, 16);
                    read_one(c * NB + 4, 0);
                end
            end
        end

        // forwarding: back-to-back same bin, plus readback gated outside DONE
        do_start();
        rd_en   = 1'b1;
        rd_addr = AW'(5);
        send_pix(5, 5, 1'b0);
        check("rd_outside_done", rd_data, 0);
        rd_en = 1'b0;
        send_pix(5, 7, 1'b0);
        send_pix(5, 9, 1'b1);
        finish_frame(1'b0);
        read_one(5, 21);

        // saturation
        do_start();
        send_pix(7, 200, 1'b0);
        send_pix(7, 200, 1'b0);
        send_pix(7, 200, 1'b1);
        finish_frame(1'b0);
        read_one(7, 255);

        // out-of-range bin dropped; pixel after frame end ignored
        do_start();
        send_pix(NB, 50, 1'b0);
        send_pix(0, 4, 1'b1);
        finish_frame(1'b1);
        check("t5_frame_err", frame_err, 1'b1);
        read_one(NB, 0);
        read_one(0, 4);

        // start ignored in ACCUM, then reset mid-frame and a clean rerun
        do_start();
        start = 1'b1;
        send_pix(1, 1, 1'b0);
        start = 1'b0;
        check("start_ignored_state", dbg_state, 3'd2);
        check("start_ignored_ready", hog_ready, 1'b1);
        send_pix(NB, 1, 1'b0);
        check("t6_err_before_reset", frame_err, 1'b1);
        pix_valid = 1'b1;
        arest_n   = 1'b0;
        #1;
        check("mid_rst_hog_ready", hog_ready, 1'b0);
        check("mid_rst_hist_done", hist_done, 1'b0);
        check("mid_rst_frame_err", frame_err, 1'b0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_state", dbg_state, 3'd0);
        pix_valid = 1'b0;
        step();
        arest_n = 1'b1;
        step();
        check("post_rst_idle", dbg_state, 3'd0);
        run_frame(vecs[1]);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
